// File: rtl/arch_map_table_pkg.sv
// Shared widths, slot bundle type and reset mapping rule
// for the architectural map table.
package arch_map_table_pkg;

    localparam int SIZE_LOGICAL = 32;
    localparam int LOG_W        = 5;
    localparam int PHY_W        = 7;
    localparam int COMMIT_WIDTH = 4;

    typedef struct packed {
        logic             valid;
        logic [LOG_W-1:0] logDest;
        logic [PHY_W-1:0] phyDest;
    } retireSlot_t;

    // Committed state starts as the identity map: rN -> pN.
    function automatic logic [PHY_W-1:0] resetMapping(input int k);
        return PHY_W'(k);
    endfunction

endpackage

// File: rtl/arch_map_table_free_select.sv
// Picks the displaced physical tag for each retire slot, letting
// older same-destination slots in the bundle shadow the AMT read.
module amt_free_select
    import arch_map_table_pkg::*;
(
    input  retireSlot_t [COMMIT_WIDTH-1:0]            slots,
    input  logic        [COMMIT_WIDTH-1:0][PHY_W-1:0] amtRead,
    output logic        [COMMIT_WIDTH-1:0][PHY_W-1:0] oldTag
);

    always_comb begin
        oldTag = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (slots[j].valid) begin
                oldTag[j] = amtRead[j];
                // Ascending scan: the youngest older match wins.
                for (int i = 0; i < j; i++) begin
                    if (slots[i].valid &&
                        slots[i].logDest == slots[j].logDest) begin
                        oldTag[j] = slots[i].phyDest;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/arch_map_table.sv
// Architectural map table: committed logical-to-physical map,
// registered frees to the free list, and flush restore image.
module arch_map_table
    import arch_map_table_pkg::*;
#(
    parameter int SIZE_LOGICAL = arch_map_table_pkg::SIZE_LOGICAL,
    parameter int LOG_W        = arch_map_table_pkg::LOG_W,
    parameter int PHY_W        = arch_map_table_pkg::PHY_W,
    parameter int COMMIT_WIDTH = arch_map_table_pkg::COMMIT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          retireValid0_i,
    input  logic                          retireValid1_i,
    input  logic                          retireValid2_i,
    input  logic                          retireValid3_i,
    input  logic [LOG_W-1:0]              retireLogDest0_i,
    input  logic [LOG_W-1:0]              retireLogDest1_i,
    input  logic [LOG_W-1:0]              retireLogDest2_i,
    input  logic [LOG_W-1:0]              retireLogDest3_i,
    input  logic [PHY_W-1:0]              retirePhyDest0_i,
    input  logic [PHY_W-1:0]              retirePhyDest1_i,
    input  logic [PHY_W-1:0]              retirePhyDest2_i,
    input  logic [PHY_W-1:0]              retirePhyDest3_i,
    input  logic                          recoverFlag_i,
    output logic                          commitValid0_o,
    output logic                          commitValid1_o,
    output logic                          commitValid2_o,
    output logic                          commitValid3_o,
    output logic [PHY_W-1:0]              commitReg0_o,
    output logic [PHY_W-1:0]              commitReg1_o,
    output logic [PHY_W-1:0]              commitReg2_o,
    output logic [PHY_W-1:0]              commitReg3_o,
    output logic [SIZE_LOGICAL*PHY_W-1:0] recoverMap_o
);

    retireSlot_t [COMMIT_WIDTH-1:0]            slots;
    logic        [COMMIT_WIDTH-1:0][PHY_W-1:0] amtRead;
    logic        [COMMIT_WIDTH-1:0][PHY_W-1:0] oldTag;

    logic [PHY_W-1:0] amt     [SIZE_LOGICAL];
    logic [PHY_W-1:0] amtNext [SIZE_LOGICAL];

    logic [COMMIT_WIDTH-1:0]            commitValid;
    logic [COMMIT_WIDTH-1:0][PHY_W-1:0] commitReg;

    // Flush only redirects the rename map; retirement is unaffected.
    logic unusedRecover;
    assign unusedRecover = recoverFlag_i;

    assign slots[0] = '{retireValid0_i, retireLogDest0_i, retirePhyDest0_i};
    assign slots[1] = '{retireValid1_i, retireLogDest1_i, retirePhyDest1_i};
    assign slots[2] = '{retireValid2_i, retireLogDest2_i, retirePhyDest2_i};
    assign slots[3] = '{retireValid3_i, retireLogDest3_i, retirePhyDest3_i};

    always_comb begin
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            amtRead[j] = amt[slots[j].logDest];
        end
    end

    amt_free_select u_freeSelect (
        .slots   (slots),
        .amtRead (amtRead),
        .oldTag  (oldTag)
    );

    // Later slots overwrite earlier ones: youngest writer wins.
    always_comb begin
        amtNext = amt;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (slots[i].valid) begin
                amtNext[slots[i].logDest] = slots[i].phyDest;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SIZE_LOGICAL; k++) begin
                amt[k] <= resetMapping(k);
            end
            commitValid <= '0;
            commitReg   <= '0;
        end else begin
            amt <= amtNext;
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                commitValid[j] <= slots[j].valid;
            end
            commitReg <= oldTag;
        end
    end

    assign commitValid0_o = commitValid[0];
    assign commitValid1_o = commitValid[1];
    assign commitValid2_o = commitValid[2];
    assign commitValid3_o = commitValid[3];
    assign commitReg0_o   = commitReg[0];
    assign commitReg1_o   = commitReg[1];
    assign commitReg2_o   = commitReg[2];
    assign commitReg3_o   = commitReg[3];

    for (genvar k = 0; k < SIZE_LOGICAL; k++) begin : g_map
        assign recoverMap_o[k*PHY_W +: PHY_W] = amt[k];
    end

endmodule

// File: tb/tb_arch_map_table.sv
// Self-checking bench for arch_map_table: per-cycle reference model
// plus literal expectations from hand-worked retire bundles.
module tb_arch_map_table;

    logic         clk = 1'b0;
    logic         reset;
    logic         rv0, rv1, rv2, rv3;
    logic [4:0]   rl0, rl1, rl2, rl3;
    logic [6:0]   rp0, rp1, rp2, rp3;
    logic         recoverFlag;
    logic         cv0, cv1, cv2, cv3;
    logic [6:0]   cr0, cr1, cr2, cr3;
    logic [223:0] recoverMap;

    int compared   = 0;
    int mismatched = 0;

    int mdl [32];
    int expReg [4];
    bit [3:0] expValid;
    bit mdlReady = 1'b0;

    always #5 clk = ~clk;

    arch_map_table dut (
        .clk              (clk),
        .reset            (reset),
        .retireValid0_i   (rv0),
        .retireValid1_i   (rv1),
        .retireValid2_i   (rv2),
        .retireValid3_i   (rv3),
        .retireLogDest0_i (rl0),
        .retireLogDest1_i (rl1),
        .retireLogDest2_i (rl2),
        .retireLogDest3_i (rl3),
        .retirePhyDest0_i (rp0),
        .retirePhyDest1_i (rp1),
        .retirePhyDest2_i (rp2),
        .retirePhyDest3_i (rp3),
        .recoverFlag_i    (recoverFlag),
        .commitValid0_o   (cv0),
        .commitValid1_o   (cv1),
        .commitValid2_o   (cv2),
        .commitValid3_o   (cv3),
        .commitReg0_o     (cr0),
        .commitReg1_o     (cr1),
        .commitReg2_o     (cr2),
        .commitReg3_o     (cr3),
        .recoverMap_o     (recoverMap)
    );

    function automatic int dutMap(input int k);
        return int'(recoverMap[k*7 +: 7]);
    endfunction

    function automatic int dutReg(input int s);
        case (s)
            0: return int'(cr0);
            1: return int'(cr1);
            2: return int'(cr2);
            default: return int'(cr3);
        endcase
    endfunction

    // Reference: retire slots in program order against a plain array.
    always @(posedge clk) begin
        bit   v [4];
        int   ld [4];
        int   pd [4];
        v  = '{rv0, rv1, rv2, rv3};
        ld = '{int'(rl0), int'(rl1), int'(rl2), int'(rl3)};
        pd = '{int'(rp0), int'(rp1), int'(rp2), int'(rp3)};
        if (reset) begin
            for (int k = 0; k < 32; k++) mdl[k] = k;
            expValid = '0;
            for (int s = 0; s < 4; s++) expReg[s] = 0;
            mdlReady = 1'b1;
        end else if (mdlReady) begin
            for (int s = 0; s < 4; s++) begin
                expValid[s] = v[s];
                expReg[s]   = 0;
                if (v[s]) begin
                    expReg[s]  = mdl[ld[s]];
                    mdl[ld[s]] = pd[s];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mdlReady) begin
            compared++;
            if ({cv3, cv2, cv1, cv0} !== expValid) begin
                mismatched++;
                $display("FAIL model.valid got %b want %b",
                         {cv3, cv2, cv1, cv0}, expValid);
            end
            for (int s = 0; s < 4; s++) begin
                compared++;
                if (dutReg(s) != expReg[s]) begin
                    mismatched++;
                    $display("FAIL model.commitReg%0d got %0d want %0d",
                             s, dutReg(s), expReg[s]);
                end
            end
            for (int k = 0; k < 32; k++) begin
                compared++;
                if (dutMap(k) != mdl[k]) begin
                    mismatched++;
                    $display("FAIL model.map[%0d] got %0d want %0d",
                             k, dutMap(k), mdl[k]);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] v,
                        input int l0, input int p0,
                        input int l1, input int p1,
                        input int l2, input int p2,
                        input int l3, input int p3,
                        input logic rec, input logic rst);
        {rv3, rv2, rv1, rv0} = v;
        rl0 = 5'(l0); rp0 = 7'(p0);
        rl1 = 5'(l1); rp1 = 7'(p1);
        rl2 = 5'(l2); rp2 = 7'(p2);
        rl3 = 5'(l3); rp3 = 7'(p3);
        recoverFlag = rec;
        reset = rst;
        @(posedge clk);
        #3;
    endtask

    task automatic idle();
        step(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    function automatic int validVec();
        return int'({cv3, cv2, cv1, cv0});
    endfunction

    initial begin
        int bad;
        reset = 1'b1;
        {rv3, rv2, rv1, rv0} = '0;
        rl0 = '0; rl1 = '0; rl2 = '0; rl3 = '0;
        rp0 = '0; rp1 = '0; rp2 = '0; rp3 = '0;
        recoverFlag = 1'b0;

        step(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        step(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        bad = 0;
        for (int k = 0; k < 32; k++) if (dutMap(k) != k) bad++;
        chk("reset.identityMisses", bad, 0);
        chk("reset.valids", validVec(), 0);

        step(4'b0001, 3, 40, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("single.valids", validVec(), 1);
        chk("single.reg0", int'(cr0), 3);
        chk("single.map3", dutMap(3), 40);

        step(4'b1111, 5, 50, 5, 51, 5, 52, 5, 53, 1'b0, 1'b0);
        chk("same4.valids", validVec(), 15);
        chk("same4.reg0", int'(cr0), 5);
        chk("same4.reg1", int'(cr1), 50);
        chk("same4.reg2", int'(cr2), 51);
        chk("same4.reg3", int'(cr3), 52);
        chk("same4.map5", dutMap(5), 53);

        step(4'b1010, 0, 0, 2, 60, 0, 0, 7, 61, 1'b0, 1'b0);
        chk("gap.valids", validVec(), 10);
        chk("gap.reg0", int'(cr0), 0);
        chk("gap.reg1", int'(cr1), 2);
        chk("gap.reg2", int'(cr2), 0);
        chk("gap.reg3", int'(cr3), 7);

        step(4'b0001, 4, 70, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("b2b.first", int'(cr0), 4);
        step(4'b0001, 4, 71, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("b2b.second", int'(cr0), 70);

        step(4'b0001, 9, 80, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("recover.map9", dutMap(9), 80);
        chk("recover.reg0", int'(cr0), 9);

        step(4'b1111, 1, 90, 2, 91, 1, 92, 3, 93, 1'b0, 1'b0);
        chk("mixed.reg0", int'(cr0), 1);
        chk("mixed.reg1", int'(cr1), 60);
        chk("mixed.reg2", int'(cr2), 90);
        chk("mixed.reg3", int'(cr3), 40);
        chk("mixed.map1", dutMap(1), 92);

        for (int n = 0; n < 200; n++) begin
            step(4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                 1'($urandom_range(0, 1)), 1'b0);
        end

        step(4'b1111, 6, 100, 7, 101, 8, 102, 6, 103, 1'b1, 1'b1);
        bad = 0;
        for (int k = 0; k < 32; k++) if (dutMap(k) != k) bad++;
        chk("rstRetire.identityMisses", bad, 0);
        chk("rstRetire.valids", validVec(), 0);
        chk("rstRetire.reg0", int'(cr0), 0);
        idle();
        chk("postRst.valids", validVec(), 0);
        idle();

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
